multicycle_core: RTL
====================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL take parameter WIDTH, default 32, datapath and register width in bits (minimum 32).
REQ-002 SHALL take parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL take parameter NREG, default 32, register-file depth (fixed at 32 for MIPS encoding; a register index is 5 bits).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port memreq, output, 1 bit: memory access request.
REQ-007 SHALL have port memwe, output, 1 bit: the request is a write.
REQ-008 SHALL have port adr, output, WIDTH bits: byte address of the access.
REQ-009 SHALL have port writedata, output, WIDTH bits: store data.
REQ-010 SHALL have port readdata, input, WIDTH bits: load or fetch data.
REQ-011 SHALL have port memready, input, 1 bit: the access completes this cycle.
REQ-012 SHALL have port halted, output, 1 bit: illegal instruction trapped.
REQ-013 SHALL have port state_o, output, 4 bits: current FSM state, for debug.

Function
REQ-014 SHALL integrate the multicycle datapath and its control FSM, adding a memory-wait handshake, bne, ori and an illegal-instruction trap.
REQ-015 SHALL use FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP, HALT.
REQ-016 In FETCH, SHALL drive memreq=1, memwe=0, adr=PC; hold in FETCH while memready=0; when memready=1, load IR<=readdata, PC<=PC+4 and go to DECODE.
REQ-017 In DECODE, SHALL latch A<=rf[rs] and B<=rf[rt], set ALUOut<=PC+(signext(imm)<<2), and dispatch on opcode.
REQ-018 SHALL dispatch: lw 100011 and sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 and bne 000101 -> BRANCH; addi 001000 and ori 001101 -> IEXEC; j 000010 -> JUMP; any other opcode -> HALT.
REQ-019 MEMADR SHALL compute ALUOut<=A+signext(imm), then go to MEMRD for lw or MEMWR for sw.
REQ-020 MEMRD SHALL drive memreq=1, adr=ALUOut and wait for memready; on memready, capture Data<=readdata and go to MEMWB. MEMWB SHALL write rf[rt]<=Data and go to FETCH.
REQ-021 MEMWR SHALL drive memreq=1, memwe=1, adr=ALUOut, writedata=B and hold until memready, then go to FETCH.
REQ-022 EXEC SHALL implement funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed). Any other funct SHALL go to HALT without a register write. ALUWB SHALL write rf[rd].
REQ-023 IEXEC SHALL compute A+signext(imm) for addi or A|zeroext(imm) for ori. IWB SHALL write rf[rt].
REQ-024 BRANCH SHALL set PC<=ALUOut when (A==B) for beq or (A!=B) for bne, then go to FETCH.
REQ-025 JUMP SHALL set PC<={PC[31:28], instr[25:0], 2'b00}, then go to FETCH.
REQ-026 With zero wait states, latency SHALL be: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3 cycles. Each memready=0 cycle adds exactly one cycle.
REQ-027 Register 0 SHALL read as zero; writes to it SHALL be discarded.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow trap.
REQ-029 HALT SHALL assert halted=1 and memreq=0, and SHALL hold PC, registers and state until reset.
REQ-030 memreq SHALL be 0 in every state other than FETCH, MEMRD and MEMWR; memwe SHALL be 1 only in MEMWR.

Reset
REQ-031 While reset=1, SHALL set state FETCH, PC=RESET_PC, IR=0, A=B=ALUOut=Data=0, memreq=0, memwe=0, halted=0.
REQ-032 reset SHALL take priority over memready and any state transition, including mid-access and in HALT; an aborted store SHALL not be reissued.
REQ-033 Register-file contents other than register 0 SHALL be undefined after reset.

Structure
REQ-034 Package mc_pkg SHALL hold the opcode and funct constants, the state enumeration and the ALU-control codes.
REQ-035 The FSM SHALL be a sub-module mc_ctrl; the datapath registers, register file and ALU SHALL sit in multicycle_core.

Verification
REQ-036 Reset, then memory word 0 = addi $2,$0,5 with memready held 1 -> $2=5 after 4 cycles, PC=4.
REQ-037 lw $3,8($0) with mem[8]=0xDEADBEEF and memready low for 3 cycles in MEMRD -> $3=0xDEADBEEF after 8 cycles.
REQ-038 bne $1,$2,-2 with $1=1, $2=2 at PC=0x10 -> PC=0x0C after 3 cycles; with $1=$2 -> PC=0x14.
REQ-039 ori $4,$0,0x8000 -> $4=0x00008000 (zero-extended); addi with immediate 0x8000 -> 0xFFFF8000.
REQ-040 Opcode 111111 -> halted=1, memreq=0 persisting 20 cycles; after reset, halted=0 and PC=RESET_PC.
REQ-041 Reset asserted during MEMWR with memready=0 -> no write issued after release, state FETCH, adr=RESET_PC.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs,
// FSM states, ALU codes and the control word the FSM hands the datapath.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;
    typedef enum logic [1:0] {SRCB_REG, SRCB_SEXT, SRCB_SEXT4, SRCB_ZEXT} srcb_e;
    typedef enum logic [1:0] {PC_INC, PC_ALU, PC_JUMP} pcsel_e;

    typedef struct packed {
        logic   memreq;
        logic   memwe;
        logic   adr_alu;   // address from ALUOut instead of PC
        logic   ir_we;
        logic   pc_we;
        pcsel_e pc_sel;
        logic   ab_we;
        logic   alu_we;
        logic   srca_reg;  // ALU A operand from A register instead of PC
        srcb_e  srcb;
        alu_e   alu_op;
        logic   data_we;
        logic   rf_we;
        logic   rf_rd;     // write rd instead of rt
        logic   rf_data;   // write Data instead of ALUOut
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl.sv
// Control FSM: sequences each instruction through fetch/decode/execute
// states and emits a one-hot-ish control word for the datapath.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       memready,
    input  logic       a_eq_b,
    output state_e     state,
    output ctrl_t      ctrl
);

    state_e next;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        ctrl        = '0;
        ctrl.pc_sel = PC_INC;
        ctrl.srcb   = SRCB_REG;
        ctrl.alu_op = ALU_ADD;
        case (state)
            S_FETCH: begin
                ctrl.memreq = 1'b1;
                ctrl.ir_we  = memready;
                ctrl.pc_we  = memready;
                if (memready) next = S_DECODE;
            end
            S_DECODE: begin
                // branch target is computed here, off the already-incremented PC
                ctrl.ab_we  = 1'b1;
                ctrl.alu_we = 1'b1;
                ctrl.srcb   = SRCB_SEXT4;
                case (op)
                    OP_LW, OP_SW:    next = S_MEMADR;
                    OP_RTYPE:        next = S_EXEC;
                    OP_BEQ, OP_BNE:  next = S_BRANCH;
                    OP_ADDI, OP_ORI: next = S_IEXEC;
                    OP_J:            next = S_JUMP;
                    default:         next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_we   = 1'b1;
                ctrl.srca_reg = 1'b1;
                ctrl.srcb     = SRCB_SEXT;
                next          = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.memreq  = 1'b1;
                ctrl.adr_alu = 1'b1;
                ctrl.data_we = memready;
                if (memready) next = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.rf_we   = 1'b1;
                ctrl.rf_data = 1'b1;
                next         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.memreq  = 1'b1;
                ctrl.memwe   = 1'b1;
                ctrl.adr_alu = 1'b1;
                if (memready) next = S_FETCH;
            end
            S_EXEC: begin
                ctrl.srca_reg = 1'b1;
                ctrl.alu_we   = 1'b1;
                next          = S_ALUWB;
                case (funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_SUB: ctrl.alu_op = ALU_SUB;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_OR:  ctrl.alu_op = ALU_OR;
                    FN_SLT: ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.alu_we = 1'b0;
                        next        = S_HALT;
                    end
                endcase
            end
            S_ALUWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.rf_rd = 1'b1;
                next       = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.pc_we  = (op == OP_BNE) ? !a_eq_b : a_eq_b;
                ctrl.pc_sel = PC_ALU;
                next        = S_FETCH;
            end
            S_IEXEC: begin
                ctrl.alu_we   = 1'b1;
                ctrl.srca_reg = 1'b1;
                ctrl.srcb     = (op == OP_ORI) ? SRCB_ZEXT : SRCB_SEXT;
                ctrl.alu_op   = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                next          = S_IWB;
            end
            S_IWB: begin
                ctrl.rf_we = 1'b1;
                next       = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_sel = PC_JUMP;
                next        = S_FETCH;
            end
            S_HALT:  next = S_HALT;
            default: next = S_HALT;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: datapath registers, register file and ALU,
// sequenced by mc_ctrl over a single request/ready memory port.
module multicycle_core
    import mc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               NREG     = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             memreq,
    output logic             memwe,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] readdata,
    input  logic             memready,
    output logic             halted,
    output logic [3:0]       state_o
);

    logic [WIDTH-1:0] pc, ir, a, b, aluout, data;
    logic [WIDTH-1:0] rf [NREG];
    logic [WIDTH-1:0] sext, zext, srca, srcb, alu_y, pc_next, rd_a, rd_b, wd;
    logic [4:0]       rs, rt, rd, wa;
    logic [15:0]      imm;
    state_e           state;
    ctrl_t            ctrl;

    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign imm  = ir[15:0];
    assign sext = {{(WIDTH-16){imm[15]}}, imm};
    assign zext = {{(WIDTH-16){1'b0}}, imm};

    mc_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .op       (ir[31:26]),
        .funct    (ir[5:0]),
        .memready (memready),
        .a_eq_b   (a == b),
        .state    (state),
        .ctrl     (ctrl)
    );

    assign rd_a = (rs == 5'd0) ? '0 : rf[rs];
    assign rd_b = (rt == 5'd0) ? '0 : rf[rt];

    assign srca = ctrl.srca_reg ? a : pc;
    always_comb begin
        case (ctrl.srcb)
            SRCB_SEXT:  srcb = sext;
            SRCB_SEXT4: srcb = sext << 2;
            SRCB_ZEXT:  srcb = zext;
            default:    srcb = b;
        endcase
    end

    always_comb begin
        case (ctrl.alu_op)
            ALU_SUB: alu_y = srca - srcb;
            ALU_AND: alu_y = srca & srcb;
            ALU_OR:  alu_y = srca | srcb;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            default: alu_y = srca + srcb;
        endcase
    end

    always_comb begin
        case (ctrl.pc_sel)
            PC_ALU:  pc_next = aluout;
            PC_JUMP: pc_next = {pc[WIDTH-1:28], ir[25:0], 2'b00};
            default: pc_next = pc + WIDTH'(4);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            data   <= '0;
        end else begin
            if (ctrl.pc_we)   pc     <= pc_next;
            if (ctrl.ir_we)   ir     <= readdata;
            if (ctrl.ab_we)   a      <= rd_a;
            if (ctrl.ab_we)   b      <= rd_b;
            if (ctrl.alu_we)  aluout <= alu_y;
            if (ctrl.data_we) data   <= readdata;
        end
    end

    // register file is not reset; r0 is never written and reads as zero
    assign wa = ctrl.rf_rd ? rd : rt;
    assign wd = ctrl.rf_data ? data : aluout;
    always_ff @(posedge clk) begin
        if (!reset && ctrl.rf_we && wa != 5'd0) rf[wa] <= wd;
    end

    // reset masks the bus immediately so an in-flight store is abandoned
    assign memreq    = ctrl.memreq && !reset;
    assign memwe     = ctrl.memwe && !reset;
    assign halted    = (state == S_HALT) && !reset;
    assign adr       = ctrl.adr_alu ? aluout : pc;
    assign writedata = b;
    assign state_o   = state;

endmodule
